uart_tx: RTL
============

# uart_tx

UART transmitter for the UART/ALU datapath. It serializes one byte per request into a standard asynchronous frame: 1 start bit, NB_DATA data bits LSB-first, then a stop period. It is paced by the shared 16x-oversampling baud tick and drives the serial output pin. It is the transmit counterpart of the receiver in top_level_uart and returns ALU results to the host.

## Interface
- NB_DATA, 8, data bits per frame
- SB_TICK, 16, baud ticks in the stop period (16 = 1 stop bit, 24 = 1.5, 32 = 2)
- N_TICK, 16, baud ticks per start or data bit (oversampling factor)

Ports:
- clock  in  1  system clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset
- i_tick  in  1  baud tick from the rate generator; one-clock pulse, N_TICK per bit time
- i_tx_start  in  1  transmit request; sampled only in IDLE
- i_data  in  NB_DATA  byte to send; captured on the accepting edge
- o_tx  out  1  serial line, registered; idles high
- o_tx_done  out  1  one-clock pulse when a frame completes
- o_busy  out  1  high while a frame is in progress (state != IDLE)

## Operation
- Reset (reset=0): state=IDLE, tick counter=0, bit index=0, shift register=0, o_tx=1, o_tx_done=0, o_busy=0.
  - Outputs take these values immediately and hold them while reset=0.
  - A frame in progress is aborted; no done pulse is generated.
- State machine: IDLE -> START -> DATA -> STOP -> IDLE.
- IDLE:
  - o_tx=1.
  - If i_tx_start=1: capture i_data into the shift register, clear the tick counter, clear the bit index, go to START.
  - Without i_tx_start, stay in IDLE.
- START:
  - o_tx=0.
  - On each i_tick: if counter==N_TICK-1, clear it and go to DATA; otherwise increment it.
- DATA:
  - o_tx = shift register bit 0.
  - On i_tick with counter==N_TICK-1: clear the counter and shift the register right one bit.
    - If bit index==NB_DATA-1, go to STOP; otherwise increment the bit index.
  - On any other i_tick, increment the counter.
- STOP:
  - o_tx=1.
  - On i_tick with counter==SB_TICK-1: go to IDLE and assert o_tx_done for the next clock.
  - On any other i_tick, increment the counter.
- Cycles without i_tick leave all state unchanged.
- i_tx_start outside IDLE is ignored. Changes on i_data after capture do not affect the frame.
- Tick counter width is clog2(max(N_TICK, SB_TICK)). Bit index width is clog2(NB_DATA). Neither counter wraps: both are cleared at their terminal values.

## Timing
- o_tx is a registered output. It reflects the new state one clock after the transition edge.
  - Example: o_tx falls one clock after the edge that accepts i_tx_start.
- o_busy rises on that same edge.
- Frame length is (1+NB_DATA)*N_TICK + SB_TICK ticks. With the defaults this is 160 ticks.
- Each start or data bit lasts exactly N_TICK ticks, measured from state entry.
  - Tick phase is not realigned at start, so the first bit may be up to one tick period short in clocks.
- o_tx_done is high for exactly one clock: the first clock back in IDLE. o_busy=0 in that same clock.
- Back-to-back frames: i_tx_start high during the o_tx_done clock is accepted. o_tx then stays 1 for one extra clock beyond the stop period before the next start bit.
- i_tick and i_tx_start arriving in the same IDLE clock: the request is accepted and that tick is not counted.

## Test plan
- Reset mid-DATA of a 0x5A frame: drive reset=0 -> o_tx=1, o_busy=0, o_tx_done=0 before the next clock edge. After release the line stays idle until a new request.
- Send 0x05 with i_tick every clock -> o_tx sequence 0,1,0,1,0,0,0,0,0,1, each value held 16 clocks. A single o_tx_done pulse follows 160 ticks after the start bit.
- Send 0x50 with i_tick every 163 clocks -> each bit lasts 16*163 clocks and the data bits read 0,0,0,0,1,0,1,0. The byte decoded by top_level_uart's receiver equals 0x50.
- Request 0x65 during a 0x05 frame, changing i_data mid-frame -> the current frame still carries 0x05, the second request is ignored, and only one done pulse occurs.
- Hold i_tx_start=1 with i_data=0x65 for two frames -> two identical frames. Between them o_tx stays high for 16 ticks plus one clock, and o_tx_done pulses twice.
- SB_TICK=32 build, send 0xFF -> the stop high period lasts 32 ticks and the total frame is 176 ticks.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: 1 start bit, NB_DATA data bits LSB-first, SB_TICK-tick stop period.
// Paced by a 16x oversampling baud tick; the serial line is registered and idles high.
module uart_tx #(
  parameter int unsigned NB_DATA = 8,
  parameter int unsigned SB_TICK = 16,
  parameter int unsigned N_TICK  = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_tick,
  input  logic               i_tx_start,
  input  logic [NB_DATA-1:0] i_data,
  output logic               o_tx,
  output logic               o_tx_done,
  output logic               o_busy
);

  localparam int unsigned MaxTick = (N_TICK > SB_TICK) ? N_TICK : SB_TICK;
  localparam int unsigned CntW    = (MaxTick > 1) ? $clog2(MaxTick) : 1;
  localparam int unsigned IdxW    = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  localparam logic [CntW-1:0] BitLast  = CntW'(N_TICK - 1);
  localparam logic [CntW-1:0] StopLast = CntW'(SB_TICK - 1);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(NB_DATA - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic [NB_DATA-1:0] shift_q, shift_d;
  logic               tx_q, tx_d;
  logic               done_q, done_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    unique case (state_q)
      StIdle: begin
        // A tick coinciding with the request is deliberately not counted.
        if (i_tx_start) begin
          shift_d = i_data;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (i_tick) begin
          if (cnt_q == BitLast) begin
            cnt_d   = '0;
            state_d = StData;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StData: begin
        if (i_tick) begin
          if (cnt_q == BitLast) begin
            cnt_d   = '0;
            shift_d = shift_q >> 1;
            if (idx_q == IdxLast) begin
              state_d = StStop;
            end else begin
              idx_d = idx_q + IdxW'(1);
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StStop: begin
        if (i_tick) begin
          if (cnt_q == StopLast) begin
            cnt_d   = '0;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line level is registered from the current state, so it lags transitions by one clock.
  always_comb begin
    tx_d   = 1'b1;
    done_d = 1'b0;
    unique case (state_q)
      StIdle:  tx_d = 1'b1;
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_q[0];
      StStop: begin
        tx_d   = 1'b1;
        done_d = i_tick && (cnt_q == StopLast);
      end
      default: tx_d = 1'b1;
    endcase
  end

  assign o_tx      = tx_q;
  assign o_tx_done = done_q;
  assign o_busy    = (state_q != StIdle);

endmodule
